// File: rtl/sample_serializer.sv
// sample_serializer: FIFO-buffered parallel-to-serial transmitter.
// Samples are accepted on a valid/ready strobe, buffered in a small FIFO and
// shifted out MSB-first on a three-wire link (sclk, sdata, fs).
//
// Parameters:
//   W        sample width
//   DEPTH    FIFO depth in samples (power of two, >= 2)
//   CLK_DIV  CLK cycles per serial bit (even, >= 2)
// Ports:
//   CLK, rst      clock; synchronous active-high reset
//   sample_in     signed sample, two's complement
//   sample_valid  sample_in is presented this cycle
//   sample_ready  FIFO not full; write happens on valid && ready
//   sclk          serial bit clock; receiver samples sdata on its rising edge
//   sdata         serial data, MSB first
//   fs            frame sync, high during the MSB bit period
//   busy          FSM active or FIFO not empty
//   overflow      sticky; a sample arrived while the FIFO was full
// Build option: define SER_PARITY_EN to append an even-parity bit per frame.
// All serial outputs are registered, so they trail the internal counters by
// one cycle; sdata therefore only moves when sclk is low.

module sample_serializer #(
    parameter int W       = 12,
    parameter int DEPTH   = 4,
    parameter int CLK_DIV = 4
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic signed [W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                sclk,
    output logic                sdata,
    output logic                fs,
    output logic                busy,
    output logic                overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(W);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [W-1:0]  head;

    state_t        state;
    logic [W-1:0]  sr;
    logic [DW-1:0] div;
    logic [BW-1:0] bit_idx;
`ifdef SER_PARITY_EN
    logic          par;
`endif

    logic push;
    logic pop;
    logic not_empty;
    logic div_last;
    logic bit_last;
    logic frame_end;

    assign sample_ready = (count != CW'(DEPTH));
    assign not_empty    = (count != '0);
    assign push         = sample_valid && sample_ready;
    assign head         = mem[rd_ptr];
    assign div_last     = (div == DW'(CLK_DIV - 1));
    assign bit_last     = (bit_idx == BW'(W - 1));

    // Frame end is the last CLK of the final bit period; a waiting sample
    // is loaded right there so the next MSB follows with no gap.
`ifdef SER_PARITY_EN
    assign frame_end = (state == PARITY) && div_last;
`else
    assign frame_end = (state == SHIFT) && div_last && bit_last;
`endif
    assign pop = not_empty && ((state == IDLE) || frame_end);

    // Storage has no reset; flushing is done through the pointers.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            state    <= IDLE;
            sr       <= '0;
            div      <= '0;
            bit_idx  <= '0;
`ifdef SER_PARITY_EN
            par      <= 1'b0;
`endif
            sclk     <= 1'b0;
            sdata    <= 1'b0;
            fs       <= 1'b0;
            busy     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (sample_valid && !sample_ready) begin
                overflow <= 1'b1;
            end

            // Registered line outputs from the current bit position.
            sclk <= (state != IDLE) && (div >= DW'(CLK_DIV / 2));
            fs   <= (state == SHIFT) && (bit_idx == '0);
            busy <= (state != IDLE) || not_empty;
`ifdef SER_PARITY_EN
            sdata <= (state == SHIFT) ? sr[W-1]
                                      : ((state == PARITY) && par);
`else
            sdata <= (state == SHIFT) && sr[W-1];
`endif

            if (pop) begin
                sr      <= head;
`ifdef SER_PARITY_EN
                par     <= ^head;
`endif
                div     <= '0;
                bit_idx <= '0;
                state   <= SHIFT;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    SHIFT: begin
                        div <= div_last ? '0 : div + 1'b1;
                        if (div_last) begin
                            if (bit_last) begin
`ifdef SER_PARITY_EN
                                state <= PARITY;
`else
                                state <= IDLE;
`endif
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                                sr      <= {sr[W-2:0], 1'b0};
                            end
                        end
                    end
`ifdef SER_PARITY_EN
                    PARITY: begin
                        div <= div_last ? '0 : div + 1'b1;
                        if (div_last) begin
                            state <= IDLE;
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
